mips_cpu_hilo_muldiv: RTL and testbench



---
 rtl/mips_cpu_pkg.sv | 28 ++
 rtl/mips_cpu_muldiv_step.sv | 41 ++++
 rtl/mips_cpu_hilo_muldiv.sv | 172 +++++++++++++++++
 tb/tb_mips_cpu_hilo_muldiv.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg
// Shared constants and types for the MIPS CPU core: the ALUOp codes that the
// control decoder emits and the multiply/divide unit consumes, the
// multiply/divide FSM state encoding, and a small magnitude helper.
// No ports (package).
package mips_cpu_pkg;

    localparam logic [4:0] ALUOP_MULT  = 5'd2;
    localparam logic [4:0] ALUOP_DIV   = 5'd3;
    localparam logic [4:0] ALUOP_MULTU = 5'd22;
    localparam logic [4:0] ALUOP_DIVU  = 5'd23;
    localparam logic [4:0] ALUOP_MTHI  = 5'd24;
    localparam logic [4:0] ALUOP_MTLO  = 5'd25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } muldiv_state_t;

    // Absolute value for signed operands, raw value for unsigned ones.
    // 32'h8000_0000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// mips_cpu_muldiv_step
// Purely combinational single iteration of the multiply/divide datapath.
//   Multiply: acc = {partial_hi, multiplier}; conditionally add the
//             multiplicand to the upper half, then shift right by one.
//   Divide:   acc = {remainder, dividend/quotient}; shift left by one,
//             trial-subtract the divisor, keep the result if no borrow and
//             shift the quotient bit in at the bottom.
// Ports:
//   is_div   in  1   select divide step (1) or multiply step (0)
//   acc      in  64  current accumulator
//   operand  in  32  multiplicand or divisor magnitude
//   acc_next out 64  accumulator after one step
module mips_cpu_muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] rem_shift;
    logic [32:0] diff;

    // The remainder is always below the divisor, so the shifted remainder
    // fits 33 bits and bit 32 of the difference is a clean borrow flag.
    always_comb begin
        sum       = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        rem_shift = acc[63:31];
        diff      = rem_shift - {1'b0, operand};
        if (is_div) begin
            if (diff[32]) begin
                acc_next = {rem_shift[31:0], acc[30:0], 1'b0};
            end else begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end
        end else begin
            acc_next = {sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/mips_cpu_hilo_muldiv.sv
// mips_cpu_hilo_muldiv
// Multi-cycle multiply/divide unit with the HI/LO register pair.
// Handles MULT, MULTU, DIV, DIVU, MTHI and MTLO; iterative ops take 32 step
// cycles plus one FIXUP cycle that applies signs and writes HI/LO.
// Optional build macro: MIPS_MULDIV_FAST_MULT_EN -- multiplies complete
// combinationally at the accept edge; divide stays iterative.
// Ports:
//   clk               in  1   rising-edge clock
//   rst_n             in  1   asynchronous active-low reset
//   CtrlALUOp         in  5   operation code
//   CtrlSpcRegWriteEn in  1   request valid
//   CtrlHiLoRead      in  1   current instruction is MFHI/MFLO
//   A                 in  32  rs value
//   B                 in  32  rt value
//   ALUHi             out 32  HI register
//   ALULo             out 32  LO register
//   Busy              out 1   operation in flight (registered)
//   Stall             out 1   hold the pipeline
module mips_cpu_hilo_muldiv
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  CtrlALUOp,
    input  logic        CtrlSpcRegWriteEn,
    input  logic        CtrlHiLoRead,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUHi,
    output logic [31:0] ALULo,
    output logic        Busy,
    output logic        Stall
);

    muldiv_state_t state, state_next;
    logic [5:0]    counter, counter_next;
    logic [63:0]   acc, acc_next, step_acc, product;
    logic [31:0]   operand, operand_next;
    logic [31:0]   hi, hi_next, lo, lo_next;
    logic          qneg, qneg_next, rneg, rneg_next, op_div, op_div_next;
    logic          is_signed, op_valid, accept;
    logic [31:0]   mag_a, mag_b;
`ifdef MIPS_MULDIV_FAST_MULT_EN
    logic [63:0]   ext_a, ext_b, fast_prod;
`endif

    assign is_signed = (CtrlALUOp == ALUOP_MULT) || (CtrlALUOp == ALUOP_DIV);
    assign op_valid  = (CtrlALUOp == ALUOP_MULT) || (CtrlALUOp == ALUOP_MULTU) ||
                       (CtrlALUOp == ALUOP_DIV)  || (CtrlALUOp == ALUOP_DIVU)  ||
                       (CtrlALUOp == ALUOP_MTHI) || (CtrlALUOp == ALUOP_MTLO);
    assign accept    = CtrlSpcRegWriteEn && (state == IDLE) && op_valid;
    assign mag_a     = magnitude(A, is_signed);
    assign mag_b     = magnitude(B, is_signed);
    assign product   = qneg ? (~acc + 64'd1) : acc;

`ifdef MIPS_MULDIV_FAST_MULT_EN
    // Sign-extending to 64 bits makes one unsigned multiply serve both MULT and MULTU.
    assign ext_a     = {{32{is_signed & A[31]}}, A};
    assign ext_b     = {{32{is_signed & B[31]}}, B};
    assign fast_prod = ext_a * ext_b;
`endif

    mips_cpu_muldiv_step u_step (
        .is_div   (state == DIV),
        .acc      (acc),
        .operand  (operand),
        .acc_next (step_acc)
    );

    // Next-state and datapath update; qneg doubles as the product sign flag.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        acc_next     = acc;
        operand_next = operand;
        qneg_next    = qneg;
        rneg_next    = rneg;
        op_div_next  = op_div;
        hi_next      = hi;
        lo_next      = lo;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (CtrlALUOp)
                        ALUOP_MTHI: hi_next = A;
                        ALUOP_MTLO: lo_next = A;
                        ALUOP_MULT, ALUOP_MULTU: begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
                            hi_next = fast_prod[63:32];
                            lo_next = fast_prod[31:0];
`else
                            state_next   = MUL;
                            counter_next = 6'd0;
                            acc_next     = {32'd0, mag_b};
                            operand_next = mag_a;
                            qneg_next    = is_signed & (A[31] ^ B[31]);
                            rneg_next    = 1'b0;
                            op_div_next  = 1'b0;
`endif
                        end
                        ALUOP_DIV, ALUOP_DIVU: begin
                            if (B == 32'd0) begin
                                hi_next = A;
                                lo_next = 32'hFFFF_FFFF;
                            end else begin
                                state_next   = DIV;
                                counter_next = 6'd0;
                                acc_next     = {32'd0, mag_a};
                                operand_next = mag_b;
                                qneg_next    = is_signed & (A[31] ^ B[31]);
                                rneg_next    = is_signed & A[31];
                                op_div_next  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                acc_next     = step_acc;
                counter_next = counter + 6'd1;
                if (counter == 6'd31) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                if (op_div) begin
                    lo_next = qneg ? (~acc[31:0] + 32'd1) : acc[31:0];
                    hi_next = rneg ? (~acc[63:32] + 32'd1) : acc[63:32];
                end else begin
                    hi_next = product[63:32];
                    lo_next = product[31:0];
                end
                state_next   = IDLE;
                counter_next = 6'd0;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; Busy is registered from the next state so it rises at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= 6'd0;
            acc     <= 64'd0;
            operand <= 32'd0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            op_div  <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            Busy    <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            acc     <= acc_next;
            operand <= operand_next;
            qneg    <= qneg_next;
            rneg    <= rneg_next;
            op_div  <= op_div_next;
            hi      <= hi_next;
            lo      <= lo_next;
            Busy    <= (state_next != IDLE);
        end
    end

    assign ALUHi = hi;
    assign ALULo = lo;
    assign Stall = Busy & (CtrlSpcRegWriteEn | CtrlHiLoRead);

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// tb_mips_cpu_hilo_muldiv
// Self-checking bench for mips_cpu_hilo_muldiv: directed cases plus random
// operations compared against an arithmetic reference model of HI/LO.
module tb_mips_cpu_hilo_muldiv;

    localparam logic [4:0] OP_MULT  = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_MULTU = 5'd22;
    localparam logic [4:0] OP_DIVU  = 5'd23;
    localparam logic [4:0] OP_MTHI  = 5'd24;
    localparam logic [4:0] OP_MTLO  = 5'd25;
`ifdef MIPS_MULDIV_FAST_MULT_EN
    localparam int MUL_CYCLES = 0;
`else
    localparam int MUL_CYCLES = 33;
`endif
    localparam int DIV_CYCLES = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  CtrlALUOp = 5'd0;
    logic        CtrlSpcRegWriteEn = 1'b0;
    logic        CtrlHiLoRead = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] ALUHi, ALULo;
    logic        Busy, Stall;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mips_cpu_hilo_muldiv dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .CtrlALUOp         (CtrlALUOp),
        .CtrlSpcRegWriteEn (CtrlSpcRegWriteEn),
        .CtrlHiLoRead      (CtrlHiLoRead),
        .A                 (A),
        .B                 (B),
        .ALUHi             (ALUHi),
        .ALULo             (ALULo),
        .Busy              (Busy),
        .Stall             (Stall)
    );

    always #5 clk = ~clk;

    // Watchdog so a wedged design still produces a verdict.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Reference model: HI/LO after the op, and how many cycles Busy stays high.
    task automatic modelOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output int cycles);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = exp_hi;
        lo = exp_lo;
        cycles = 0;
        case (op)
            OP_MTHI: hi = a;
            OP_MTLO: lo = a;
            OP_MULT: begin
                p = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
                cycles = MUL_CYCLES;
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
                cycles = MUL_CYCLES;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                    cycles = DIV_CYCLES;
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    lo = a / b;
                    hi = a % b;
                    cycles = DIV_CYCLES;
                end
            end
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        CtrlALUOp = op;
        A = a;
        B = b;
        CtrlSpcRegWriteEn = 1'b1;
        @(posedge clk);
        #1;
        CtrlSpcRegWriteEn = 1'b0;
    endtask

    // Counts busy cycles (bounded) and checks HI/LO are untouched mid-operation.
    task automatic waitIdle(output int n, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            if (n == 5) begin
                checkOutput("hold_hi", ALUHi, hold_hi);
                checkOutput("hold_lo", ALULo, hold_lo);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runOp(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] new_hi, new_lo;
        int cycles, n;
        modelOp(op, a, b, new_hi, new_lo, cycles);
        applyStimulus(op, a, b);
        waitIdle(n, exp_hi, exp_lo);
        checkOutput({tag, "_busy"}, 32'(n), 32'(cycles));
        exp_hi = new_hi;
        exp_lo = new_lo;
        checkOutput({tag, "_hi"}, ALUHi, exp_hi);
        checkOutput({tag, "_lo"}, ALULo, exp_lo);
    endtask

    initial begin
        logic [31:0] new_hi, new_lo, ra, rb;
        logic [4:0]  ops [7];
        int          cycles, n, sel;
        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, 5'd7};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_hi", ALUHi, 32'd0);
        checkOutput("rst_lo", ALULo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu_max_hi_const", ALUHi, 32'hFFFF_FFFE);
        checkOutput("multu_max_lo_const", ALULo, 32'h0000_0001);
        runOp("mult_neg", OP_MULT, -32'sd7, 32'd3);
        checkOutput("mult_neg_lo_const", ALULo, 32'hFFFF_FFEB);
        runOp("div_neg", OP_DIV, -32'sd7, 32'd2);
        checkOutput("div_neg_lo_const", ALULo, 32'hFFFF_FFFD);
        checkOutput("div_neg_hi_const", ALUHi, 32'hFFFF_FFFF);
        runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div_ovf_lo_const", ALULo, 32'h8000_0000);
        runOp("divu_zero", OP_DIVU, 32'd100, 32'd0);
        runOp("div_zero", OP_DIV, 32'hFFFF_FF00, 32'd0);
        runOp("invalid_op", 5'd7, 32'hDEAD_BEEF, 32'd5);

        // Stall behaviour: DIVU in flight, MFLO held, second MULT queued while busy
        modelOp(OP_DIVU, 32'd1000, 32'd7, new_hi, new_lo, cycles);
        applyStimulus(OP_DIVU, 32'd1000, 32'd7);
        CtrlHiLoRead = 1'b1;
        for (int c = 0; c <= 33; c++) begin
            if (c == 10) begin
                CtrlALUOp = OP_MULT;
                A = -32'sd7;
                B = 32'd3;
                CtrlSpcRegWriteEn = 1'b1;
            end
            checkOutput("stall_busy", {31'd0, Busy}, (c < 33) ? 32'd1 : 32'd0);
            checkOutput("stall", {31'd0, Stall}, (c < 33) ? 32'd1 : 32'd0);
            if (c < 33) begin
                @(posedge clk);
                #1;
            end
        end
        exp_hi = new_hi;
        exp_lo = new_lo;
        checkOutput("mflo_after_divu", ALULo, exp_lo);
        checkOutput("mfhi_after_divu", ALUHi, exp_hi);
        modelOp(OP_MULT, -32'sd7, 32'd3, new_hi, new_lo, cycles);
        @(posedge clk);
        #1;
        CtrlSpcRegWriteEn = 1'b0;
        CtrlHiLoRead = 1'b0;
        waitIdle(n, exp_hi, exp_lo);
        checkOutput("queued_mult_busy", 32'(n), 32'(cycles));
        exp_hi = new_hi;
        exp_lo = new_lo;
        checkOutput("queued_mult_hi", ALUHi, exp_hi);
        checkOutput("queued_mult_lo", ALULo, exp_lo);
        runOp("mthi", OP_MTHI, 32'h0000_1234, 32'd0);

        // Asynchronous reset in the middle of a divide
        applyStimulus(OP_DIV, 32'd100, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        checkOutput("midop_rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("midop_rst_hi", ALUHi, exp_hi);
        checkOutput("midop_rst_lo", ALULo, exp_lo);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("mtlo_after_rst", OP_MTLO, 32'd5, 32'd0);

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            runOp("rand", ops[$urandom_range(0, 6)], ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
